xmpl_stone_feed: RTL and testbench

Upstream feeder for `xmpl_stone`. It accepts command/data requests from the processor front end over a valid/ready handshake and buffers them in a small FIFO. It then issues each request to `xmpl_stone` as a single-cycle strobe (`xmpl_stone_a_i`) with the command (`xmpl_stone_b_i`) and data word (`xmpl_stone_c_0`), and it enforces a programmable minimum idle gap between strobes.

---
 rtl/xmpl_stone_pkg.sv | 18 +
 rtl/xmpl_sync_fifo.sv | 76 +++++++
 rtl/xmpl_stone_feed.sv | 137 +++++++++++++
 tb/tb_xmpl_stone_feed.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmpl_stone_pkg.sv
// Shared types for the xmpl_stone feeder: request record and feeder FSM states.
package xmpl_stone_pkg;

  localparam int CMD_W  = 12;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } stone_req_t;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_ISSUE = 2'd1,
    FEED_GAP   = 2'd2
  } feed_state_t;

endpackage

// File: rtl/xmpl_sync_fifo.sv
// Small synchronous FIFO; occupancy is tracked by an explicit count register
// and the head entry is read straight out of the storage registers.
module xmpl_sync_fifo
  import xmpl_stone_pkg::*;
#(
  parameter int unsigned W     = $bits(stone_req_t),
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_s;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign full_s    = (count_r == CNT_W'(DEPTH));
  // Guard locally as well so a misbehaving caller cannot corrupt the count.
  assign push_ok_s = push_i && !full_s && !flush_i;
  assign pop_ok_s  = pop_i && !empty_s && !flush_i;

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (!push_ok_s && pop_ok_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Entry storage write.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end
  end

  assign head_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;
  assign empty_o = empty_s;
  assign full_o  = full_s;

endmodule

// File: rtl/xmpl_stone_feed.sv
// Feeder for xmpl_stone: buffers valid/ready requests and issues each one as
// a single-cycle strobe, keeping at least GAP idle cycles between strobes.
module xmpl_stone_feed
  import xmpl_stone_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [11:0]                req_cmd_i,
  input  logic [31:0]                req_data_i,
  input  logic                       flush_i,
  output logic                       stone_a_o,
  output logic [11:0]                stone_b_o,
  output logic [31:0]                stone_c_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       busy_o
);

  localparam int unsigned LVL_W    = $clog2(DEPTH+1);
  localparam logic        GAP_ZERO = (GAP == 0);
  localparam logic [3:0]  GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  feed_state_t       state_r;
  feed_state_t       state_s;
  logic [3:0]        gap_cnt_r;
  logic [3:0]        gap_cnt_s;
  logic              pop_s;
  logic              push_s;
  logic              ready_s;
  logic              empty_s;
  logic              full_s;
  logic [LVL_W-1:0]  level_s;
  stone_req_t        push_req_s;
  stone_req_t        head_s;
  logic              stone_a_r;
  logic [CMD_W-1:0]  stone_b_r;
  logic [DATA_W-1:0] stone_c_r;

  // No bypass when full: a same-cycle pop does not reopen the input.
  assign ready_s    = reset_n_i && (level_s < LVL_W'(DEPTH)) && !flush_i;
  assign push_s     = req_valid_i && ready_s;
  assign push_req_s = '{cmd: req_cmd_i, data: req_data_i};

  xmpl_sync_fifo #(
    .W     ($bits(stone_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (push_s),
    .push_data_i (push_req_s),
    .pop_i       (pop_s),
    .flush_i     (flush_i),
    .head_o      (head_s),
    .count_o     (level_s),
    .empty_o     (empty_s),
    .full_o      (full_s)
  );

  // Next-state, gap counter and pop decision; flush overrides any issue.
  always_comb begin
    state_s   = state_r;
    gap_cnt_s = gap_cnt_r;
    pop_s     = 1'b0;
    if (flush_i) begin
      state_s   = FEED_IDLE;
      gap_cnt_s = 4'd0;
    end else begin
      case (state_r)
        FEED_IDLE: begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_s = FEED_ISSUE;
          end else begin
            state_s = FEED_IDLE;
          end
        end
        FEED_ISSUE: begin
          if (!GAP_ZERO) begin
            state_s   = FEED_GAP;
            gap_cnt_s = GAP_LOAD;
          end else if (!empty_s) begin
            pop_s   = 1'b1;
            state_s = FEED_ISSUE;
          end else begin
            state_s = FEED_IDLE;
          end
        end
        FEED_GAP: begin
          if (gap_cnt_r != 4'd0) begin
            gap_cnt_s = gap_cnt_r - 4'd1;
          end else if (!empty_s) begin
            pop_s   = 1'b1;
            state_s = FEED_ISSUE;
          end else begin
            state_s = FEED_IDLE;
          end
        end
        default: begin
          state_s   = FEED_IDLE;
          gap_cnt_s = 4'd0;
        end
      endcase
    end
  end

  // State, counter and issue registers; b/c keep the last issued request.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r   <= FEED_IDLE;
      gap_cnt_r <= 4'd0;
      stone_a_r <= 1'b0;
      stone_b_r <= {CMD_W{1'b0}};
      stone_c_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_s;
      gap_cnt_r <= gap_cnt_s;
      stone_a_r <= pop_s;
      if (pop_s) begin
        stone_b_r <= head_s.cmd;
        stone_c_r <= head_s.data;
      end
    end
  end

  assign req_ready_o = ready_s;
  assign stone_a_o   = stone_a_r;
  assign stone_b_o   = stone_b_r;
  assign stone_c_o   = stone_c_r;
  assign level_o     = level_s;
  assign busy_o      = !empty_s || (state_r != FEED_IDLE);

endmodule

// File: tb/tb_xmpl_stone_feed.sv
// Self-checking bench: a GAP=2 and a GAP=0 feeder share one stimulus stream and
// are each compared every cycle against a queue-based timing model.
module tb_xmpl_stone_feed;
  import xmpl_stone_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [11:0] req_cmd = 12'h000;
  logic [31:0] req_data = 32'h0;
  logic        flush = 1'b0;

  logic        rdy  [2];
  logic        a_o  [2];
  logic [11:0] b_o  [2];
  logic [31:0] c_o  [2];
  logic [2:0]  lvl  [2];
  logic        busy [2];

  xmpl_stone_feed #(.DEPTH(DEPTH), .GAP(2)) u_dut_g2 (
    .clk_i(clk), .reset_n_i(reset_n), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_cmd_i(req_cmd), .req_data_i(req_data), .flush_i(flush),
    .stone_a_o(a_o[0]), .stone_b_o(b_o[0]), .stone_c_o(c_o[0]),
    .level_o(lvl[0]), .busy_o(busy[0])
  );

  xmpl_stone_feed #(.DEPTH(DEPTH), .GAP(0)) u_dut_g0 (
    .clk_i(clk), .reset_n_i(reset_n), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_cmd_i(req_cmd), .req_data_i(req_data), .flush_i(flush),
    .stone_a_o(a_o[1]), .stone_b_o(b_o[1]), .stone_c_o(c_o[1]),
    .level_o(lvl[1]), .busy_o(busy[1])
  );

  always #5 clk = ~clk;

  // reference model state
  stone_req_t  mq [2][$];
  int          last_issue [2];
  int          gaps [2];
  logic        m_ready [2];
  logic        m_a [2];
  logic [11:0] m_b [2];
  logic [31:0] m_c [2];
  logic        m_busy [2];
  int          cyc;

  int n_tests = 0;
  int n_fail  = 0;

  // observation logs
  logic        pre_rdy0;
  int          s_cyc0 [$];
  logic [11:0] s_cmd0 [$];
  int          s_cyc1 [$];
  logic [11:0] s_cmd1 [$];
  int          max_lvl0;
  int          ready_drop0;

  typedef struct {
    logic        v;
    logic [11:0] cmd;
    logic [31:0] data;
    logic        rdy;
    logic        a;
    logic [11:0] b;
    logic [31:0] c;
    logic [2:0]  lvl;
    logic        busy;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    s_cyc0.delete(); s_cmd0.delete(); s_cyc1.delete(); s_cmd1.delete();
    max_lvl0 = 0;
    ready_drop0 = 0;
  endtask

  // One clock: drive inputs, check ready, step model at the edge, check outputs.
  task automatic cycle(input logic v, input logic [11:0] cmd, input logic [31:0] data,
                       input logic fl, input logic rn);
    stone_req_t r;
    req_valid = v; req_cmd = cmd; req_data = data; flush = fl; reset_n = rn;
    #1;
    pre_rdy0 = rdy[0];
    if (rn && !fl && !rdy[0]) ready_drop0++;
    for (int k = 0; k < 2; k++) begin
      m_ready[k] = rn && (mq[k].size() < DEPTH) && !fl;
      chk("ready", k, {31'd0, rdy[k]}, {31'd0, m_ready[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        mq[k].delete();
        last_issue[k] = -1000;
        m_a[k] = 1'b0; m_b[k] = 12'h000; m_c[k] = 32'h0;
      end else if (fl) begin
        mq[k].delete();
        last_issue[k] = -1000;
        m_a[k] = 1'b0;
      end else begin
        if (mq[k].size() > 0 && (cyc - last_issue[k] > gaps[k])) begin
          r = mq[k].pop_front();
          m_a[k] = 1'b1; m_b[k] = r.cmd; m_c[k] = r.data;
          last_issue[k] = cyc;
        end else begin
          m_a[k] = 1'b0;
        end
        if (v && m_ready[k]) mq[k].push_back('{cmd: cmd, data: data});
      end
      m_busy[k] = (mq[k].size() > 0) || (cyc - last_issue[k] <= gaps[k]);
    end
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("strobe", k, {31'd0, a_o[k]}, {31'd0, m_a[k]});
      chk("cmd", k, {20'd0, b_o[k]}, {20'd0, m_b[k]});
      chk("data", k, c_o[k], m_c[k]);
      chk("level", k, {29'd0, lvl[k]}, mq[k].size());
      chk("busy", k, {31'd0, busy[k]}, {31'd0, m_busy[k]});
    end
    if (a_o[0]) begin s_cyc0.push_back(cyc); s_cmd0.push_back(b_o[0]); end
    if (a_o[1]) begin s_cyc1.push_back(cyc); s_cmd1.push_back(b_o[1]); end
    if (int'(lvl[0]) > max_lvl0) max_lvl0 = int'(lvl[0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'h000, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int budget;
    gaps[0] = 2; gaps[1] = 0;
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      last_issue[k] = -1000;
      m_a[k] = 1'b0; m_b[k] = 12'h000; m_c[k] = 32'h0; m_busy[k] = 1'b0;
    end

    // single request on the GAP=2 feeder: hand-derived per-cycle expectations
    tbl[0] = '{1'b1, 12'h0A5, 32'hDEADBEEF, 1'b1, 1'b0, 12'h000, 32'h00000000, 3'd1, 1'b1};
    tbl[1] = '{1'b0, 12'h000, 32'h00000000, 1'b1, 1'b1, 12'h0A5, 32'hDEADBEEF, 3'd0, 1'b1};
    tbl[2] = '{1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0, 12'h0A5, 32'hDEADBEEF, 3'd0, 1'b1};
    tbl[3] = '{1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0, 12'h0A5, 32'hDEADBEEF, 3'd0, 1'b1};
    tbl[4] = '{1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0, 12'h0A5, 32'hDEADBEEF, 3'd0, 1'b0};
    tbl[5] = '{1'b0, 12'h000, 32'h00000000, 1'b1, 1'b0, 12'h0A5, 32'hDEADBEEF, 3'd0, 1'b0};

    // reset state
    cycle(1'b1, 12'hFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("rst_ready", 0, {31'd0, pre_rdy0}, 32'd0);
    cycle(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
    chk("rst_strobe", 0, {31'd0, a_o[0]}, 32'd0);
    chk("rst_cmd", 0, {20'd0, b_o[0]}, 32'd0);
    chk("rst_level", 0, {29'd0, lvl[0]}, 32'd0);
    chk("rst_busy", 0, {31'd0, busy[0]}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].cmd, tbl[i].data, 1'b0, 1'b1);
      chk("t_ready", i, {31'd0, pre_rdy0}, {31'd0, tbl[i].rdy});
      chk("t_strobe", i, {31'd0, a_o[0]}, {31'd0, tbl[i].a});
      chk("t_cmd", i, {20'd0, b_o[0]}, {20'd0, tbl[i].b});
      chk("t_data", i, c_o[0], tbl[i].c);
      chk("t_level", i, {29'd0, lvl[0]}, {29'd0, tbl[i].lvl});
      chk("t_busy", i, {31'd0, busy[0]}, {31'd0, tbl[i].busy});
    end

    // backlog with GAP=2: strobes 3 cycles apart, level peaks at 3
    idle(4); clear_logs();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 12'(i), 32'(i * 32'h1111), 1'b0, 1'b1);
    idle(12);
    chk("bl_count", 0, s_cmd0.size(), 32'd4);
    for (int i = 0; i < s_cmd0.size() && i < 4; i++) begin
      chk("bl_order", i, {20'd0, s_cmd0[i]}, 32'(i + 1));
      if (i > 0) chk("bl_spacing", i, s_cyc0[i] - s_cyc0[i-1], 32'd3);
    end
    chk("bl_peak", 0, max_lvl0, 32'd3);
    chk("bl_ready_drop", 0, ready_drop0, 32'd0);

    // full FIFO: source holds its request while ready is low
    idle(4); clear_logs();
    idx = 0; budget = 60;
    while (idx < 8 && budget > 0) begin
      cycle(1'b1, 12'(12'h100 + idx), 32'(32'hA000 + idx), 1'b0, 1'b1);
      if (pre_rdy0) idx++;
      budget--;
    end
    chk("full_pushed", 0, idx, 32'd8);
    idle(30);
    chk("full_count", 0, s_cmd0.size(), 32'd8);
    for (int i = 0; i < s_cmd0.size() && i < 8; i++)
      chk("full_order", i, {20'd0, s_cmd0[i]}, 32'(12'h100 + i));
    chk("full_peak", 0, max_lvl0, 32'd4);
    chk("full_ready_low", 0, {31'd0, ready_drop0 > 0}, 32'd1);

    // GAP=0 back-to-back strobes on the second feeder
    idle(4); clear_logs();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 12'(12'h200 + i), 32'(i), 1'b0, 1'b1);
    idle(6);
    chk("b2b_count", 1, s_cyc1.size(), 32'd3);
    if (s_cyc1.size() == 3) begin
      chk("b2b_adj1", 1, s_cyc1[1] - s_cyc1[0], 32'd1);
      chk("b2b_adj2", 1, s_cyc1[2] - s_cyc1[1], 32'd1);
      for (int i = 0; i < 3; i++) chk("b2b_cmd", i, {20'd0, s_cmd1[i]}, 32'(12'h201 + i));
    end

    // flush during GAP with 3 queued and a concurrent push
    idle(4); clear_logs();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 12'(12'h300 + i), 32'(i), 1'b0, 1'b1);
    cycle(1'b1, 12'h305, 32'h5, 1'b1, 1'b1);
    chk("fl_ready", 0, {31'd0, pre_rdy0}, 32'd0);
    chk("fl_level", 0, {29'd0, lvl[0]}, 32'd0);
    chk("fl_strobe", 0, {31'd0, a_o[0]}, 32'd0);
    idle(10);
    chk("fl_count", 0, s_cmd0.size(), 32'd1);

    // reset during a strobe with 2 queued, then normal operation
    idle(4); clear_logs();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 12'(12'h400 + i), 32'(i), 1'b0, 1'b1);
    idle(1);
    chk("rm_strobe_pre", 0, {31'd0, a_o[0]}, 32'd1);
    chk("rm_level_pre", 0, {29'd0, lvl[0]}, 32'd2);
    cycle(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
    chk("rm_strobe", 0, {31'd0, a_o[0]}, 32'd0);
    chk("rm_cmd", 0, {20'd0, b_o[0]}, 32'd0);
    chk("rm_data", 0, c_o[0], 32'd0);
    chk("rm_level", 0, {29'd0, lvl[0]}, 32'd0);
    chk("rm_busy", 0, {31'd0, busy[0]}, 32'd0);
    idle(8);
    chk("rm_no_late", 0, s_cmd0.size(), 32'd2);
    cycle(1'b1, 12'h4AA, 32'hCAFE0001, 1'b0, 1'b1);
    idle(3);
    chk("rm_new_count", 0, s_cmd0.size(), 32'd3);
    if (s_cmd0.size() == 3) chk("rm_new_cmd", 0, {20'd0, s_cmd0[2]}, 32'h4AA);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 6, 12'($urandom), $urandom,
            $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0);
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
